// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, colour width and update-window FSM encodings.
// vga_sync and the frame scheduler both import this package.
package vga_timing_pkg;

   localparam int H_VISIBLE = 640;
   localparam int V_VISIBLE = 480;
   localparam int V_TOTAL   = 525;
   localparam int COLOR_W   = 12;

   localparam logic [1:0] ST_DISPLAY = 2'd0;
   localparam logic [1:0] ST_OPEN    = 2'd1;
   localparam logic [1:0] ST_GRANTED = 2'd2;
   localparam logic [1:0] ST_CLOSED  = 2'd3;

   typedef enum logic [1:0] {
      S_DISPLAY = ST_DISPLAY,
      S_OPEN    = ST_OPEN,
      S_GRANTED = ST_GRANTED,
      S_CLOSED  = ST_CLOSED
   } upd_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/vga_layer_mux.sv
// Fixed-priority layer select: the lowest-index opaque layer wins,
// BG_COLOR when no layer reports a hit.
module vga_layer_mux #(
   parameter int NUM_LAYERS = 4,
   parameter logic [vga_timing_pkg::COLOR_W-1:0] BG_COLOR = '0
) (
   input  logic [NUM_LAYERS-1:0]                          layer_hit,
   input  logic [vga_timing_pkg::COLOR_W*NUM_LAYERS-1:0]  layer_rgb,
   output logic [vga_timing_pkg::COLOR_W-1:0]             sel_rgb
);
   import vga_timing_pkg::*;

   // Walk from lowest priority upward so layer 0 overwrites last.
   always_comb begin
      sel_rgb = BG_COLOR;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_hit[i]) sel_rgb = layer_rgb[i*COLOR_W +: COLOR_W];
      end
   end

endmodule

// File: rtl/vga_frame_scheduler.sv
// Pixel compositor with sync realignment and a once-per-frame game-update window.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   DISPLAY   | active scan (or waiting out vblank after reset); no window
//   OPEN      | vblank started, waiting for upd_req
//   GRANTED   | upd_grant high, game logic may touch layer state
//   CLOSED    | update done this frame; further requests wait for next frame
module vga_frame_scheduler #(
   parameter int NUM_LAYERS  = 4,
   parameter int LAT         = 1,
   parameter int H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
   parameter int V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
   parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
   parameter int GUARD_LINES = 2,
   parameter logic [vga_timing_pkg::COLOR_W-1:0] BG_COLOR = 12'h000
) (
   input  logic                                          vga_clk,
   input  logic                                          clrn,
   input  logic [9:0]                                    col,
   input  logic [9:0]                                    row,
   input  logic                                          hsync_in,
   input  logic                                          vsync_in,
   output logic [9:0]                                    pix_x,
   output logic [9:0]                                    pix_y,
   input  logic [NUM_LAYERS-1:0]                         layer_hit,
   input  logic [vga_timing_pkg::COLOR_W*NUM_LAYERS-1:0] layer_rgb,
   output logic [vga_timing_pkg::COLOR_W-1:0]            rgb,
   output logic                                          hsync,
   output logic                                          vsync,
   output logic                                          frame_tick,
   input  logic                                          upd_req,
   input  logic                                          upd_done,
   output logic                                          upd_grant,
   output logic                                          upd_abort,
   output logic [7:0]                                    overrun_cnt
);
   import vga_timing_pkg::*;

   localparam int D = LAT + 2;
   localparam logic [9:0] COL_VIS_END = 10'(H_VISIBLE);
   localparam logic [9:0] ROW_VIS_END = 10'(V_VISIBLE);
   localparam logic [9:0] ROW_WIN_END = 10'(V_TOTAL - GUARD_LINES);

   logic               vis_in;
   logic               frame_evt;
   logic               we_evt;
   logic [LAT:0]       vis_pipe;
   logic [D-1:0]       hs_pipe;
   logic [D-1:0]       vs_pipe;
   logic [COLOR_W-1:0] mux_rgb;
   upd_state_e         state;
   upd_state_e         state_nxt;
   logic               abort_nxt;

   assign vis_in    = (col < COL_VIS_END) && (row < ROW_VIS_END);
   assign frame_evt = (col == 10'd0) && (row == ROW_VIS_END);
   assign we_evt    = (col == 10'd0) && (row == ROW_WIN_END);

   vga_layer_mux #(
      .NUM_LAYERS (NUM_LAYERS),
      .BG_COLOR   (BG_COLOR)
   ) u_layer_mux (
      .layer_hit (layer_hit),
      .layer_rgb (layer_rgb),
      .sel_rgb   (mux_rgb)
   );

   // vis travels alongside the layer latency so blanking lands on the same pixel.
   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         pix_x      <= '0;
         pix_y      <= '0;
         vis_pipe   <= '0;
         hs_pipe    <= '0;
         vs_pipe    <= '0;
         rgb        <= '0;
         frame_tick <= 1'b0;
      end else begin
         pix_x      <= col;
         pix_y      <= row;
         vis_pipe   <= {vis_pipe[LAT-1:0], vis_in};
         hs_pipe    <= {hs_pipe[D-2:0], hsync_in};
         vs_pipe    <= {vs_pipe[D-2:0], vsync_in};
         rgb        <= vis_pipe[LAT] ? mux_rgb : '0;
         frame_tick <= frame_evt;
      end
   end

   assign hsync = hs_pipe[D-1];
   assign vsync = vs_pipe[D-1];

   always_comb begin
      state_nxt = state;
      abort_nxt = 1'b0;
      case (state)
         S_DISPLAY: begin
            if (frame_evt) state_nxt = S_OPEN;
         end
         S_OPEN: begin
            if (we_evt)       state_nxt = S_DISPLAY;
            else if (upd_req) state_nxt = S_GRANTED;
         end
         S_GRANTED: begin
            // A done landing on the window-end sample still counts as finished.
            if (upd_done) begin
               state_nxt = we_evt ? S_DISPLAY : S_CLOSED;
            end else if (we_evt) begin
               state_nxt = S_DISPLAY;
               abort_nxt = 1'b1;
            end
         end
         S_CLOSED: begin
            if (we_evt) state_nxt = S_DISPLAY;
         end
         default: state_nxt = S_DISPLAY;
      endcase
   end

   always_ff @(posedge vga_clk or negedge clrn) begin
      if (!clrn) begin
         state       <= S_DISPLAY;
         upd_grant   <= 1'b0;
         upd_abort   <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         state     <= state_nxt;
         upd_grant <= (state_nxt == S_GRANTED);
         upd_abort <= abort_nxt;
         if (abort_nxt) overrun_cnt <= sat_inc8(overrun_cnt);
      end
   end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler: compositing vectors, pipeline alignment
// and update-window sequencing, with col/row driven directly instead of vga_sync.
module tb_vga_frame_scheduler;

   logic        vga_clk = 1'b0;
   logic        clrn;
   logic [9:0]  col, row;
   logic        hsync_in, vsync_in;
   logic [9:0]  pix_x, pix_y;
   logic [3:0]  layer_hit;
   logic [47:0] layer_rgb;
   logic [11:0] rgb;
   logic        hsync, vsync, frame_tick;
   logic        upd_req, upd_done, upd_grant, upd_abort;
   logic [7:0]  overrun_cnt;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [11:0] BG   = 12'h5A3;
   localparam logic [47:0] LRGB = {12'hC34, 12'hF0F, 12'hB12, 12'hA01};

   typedef struct {
      logic [9:0]  c;
      logic [9:0]  r;
      logic [3:0]  hit;
      logic [11:0] exp_rgb;
   } pix_vec_t;

   pix_vec_t vecs [10];

   always #5 vga_clk = ~vga_clk;

   vga_frame_scheduler #(
      .NUM_LAYERS (4),
      .LAT        (1),
      .BG_COLOR   (BG)
   ) dut (
      .vga_clk     (vga_clk),
      .clrn        (clrn),
      .col         (col),
      .row         (row),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .layer_hit   (layer_hit),
      .layer_rgb   (layer_rgb),
      .rgb         (rgb),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_tick  (frame_tick),
      .upd_req     (upd_req),
      .upd_done    (upd_done),
      .upd_grant   (upd_grant),
      .upd_abort   (upd_abort),
      .overrun_cnt (overrun_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic set_pos(input int c, input int r);
      col = 10'(c);
      row = 10'(r);
   endtask

   // Frame start sample, then one more cycle: grant is visible here if upd_req was high.
   task automatic open_window();
      set_pos(0, 480);
      tick();
      set_pos(1, 480);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_cnt;
      int rows_after [7];

      vecs[0] = '{10'd10,  10'd20,  4'b0100, 12'hF0F};
      vecs[1] = '{10'd10,  10'd20,  4'b1010, 12'hB12};
      vecs[2] = '{10'd10,  10'd20,  4'b0000, BG};
      vecs[3] = '{10'd700, 10'd20,  4'b0001, 12'h000};
      vecs[4] = '{10'd100, 10'd200, 4'b1111, 12'hA01};
      vecs[5] = '{10'd100, 10'd200, 4'b1000, 12'hC34};
      vecs[6] = '{10'd639, 10'd479, 4'b0001, 12'hA01};
      vecs[7] = '{10'd640, 10'd0,   4'b0001, 12'h000};
      vecs[8] = '{10'd5,   10'd480, 4'b0010, 12'h000};
      vecs[9] = '{10'd0,   10'd0,   4'b0000, BG};

      clrn = 1'b0;
      set_pos(5, 7);
      hsync_in = 1'b1; vsync_in = 1'b1;
      layer_hit = 4'b0001; layer_rgb = LRGB;
      upd_req = 1'b0; upd_done = 1'b0;
      #12;
      check("reset_pix_rgb", {pix_x, pix_y, rgb}, 32'd0);
      check("reset_ctl", {hsync, vsync, frame_tick, upd_grant, upd_abort, overrun_cnt}, 32'd0);
      hsync_in = 1'b0; vsync_in = 1'b0;
      clrn = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         set_pos(int'(vecs[i].c), int'(vecs[i].r));
         layer_hit = vecs[i].hit;
         repeat (4) tick();
         check($sformatf("vec%0d_rgb", i), rgb, vecs[i].exp_rgb);
         check($sformatf("vec%0d_pix", i), {pix_x, pix_y}, {vecs[i].c, vecs[i].r});
      end

      // Latency: one visible pixel with sync pulses, layer answers one cycle after pix_x.
      set_pos(700, 20); layer_hit = 4'b0000;
      repeat (4) tick();
      set_pos(10, 20); hsync_in = 1'b1; vsync_in = 1'b1;
      tick();
      set_pos(700, 20); hsync_in = 1'b0; vsync_in = 1'b0;
      check("lat_c1_pix", {pix_x, pix_y}, {10'd10, 10'd20});
      check("lat_c1_rgb", rgb, 12'h000);
      check("lat_c1_sync", {hsync, vsync}, 2'b00);
      tick();
      layer_hit = 4'b0100;
      check("lat_c2_rgb", rgb, 12'h000);
      check("lat_c2_sync", {hsync, vsync}, 2'b00);
      tick();
      layer_hit = 4'b0000;
      check("lat_c3_rgb", rgb, 12'hF0F);
      check("lat_c3_sync", {hsync, vsync}, 2'b11);
      tick();
      check("lat_c4_rgb", rgb, 12'h000);
      check("lat_c4_sync", {hsync, vsync}, 2'b00);

      // Normal update with upd_req held from row 100.
      set_pos(0, 100); upd_req = 1'b1;
      repeat (3) tick();
      check("no_grant_active", upd_grant, 1'b0);
      set_pos(0, 480);
      tick();
      check("frame_tick_rise", frame_tick, 1'b1);
      check("grant_not_yet", upd_grant, 1'b0);
      set_pos(1, 480);
      tick();
      check("grant_rise", upd_grant, 1'b1);
      check("frame_tick_pulse", frame_tick, 1'b0);
      repeat (50) tick();
      check("grant_held", upd_grant, 1'b1);
      upd_done = 1'b1;
      tick();
      upd_done = 1'b0;
      check("grant_fall_done", upd_grant, 1'b0);
      check("no_abort_done", upd_abort, 1'b0);
      repeat (10) tick();
      check("one_grant_per_frame", upd_grant, 1'b0);
      set_pos(0, 523);
      tick();
      check("closed_we_abort", upd_abort, 1'b0);
      check("closed_we_cnt", overrun_cnt, 8'd0);
      set_pos(1, 524);
      tick();

      // Next frame: held request earns a fresh grant; no done -> overrun.
      open_window();
      check("second_frame_grant", upd_grant, 1'b1);
      set_pos(0, 523);
      tick();
      check("overrun_grant_fall", upd_grant, 1'b0);
      check("overrun_abort", upd_abort, 1'b1);
      check("overrun_cnt1", overrun_cnt, 8'd1);
      set_pos(1, 524);
      tick();
      check("abort_one_cycle", upd_abort, 1'b0);
      check("overrun_cnt_hold", overrun_cnt, 8'd1);

      // Window opens without a request and closes quietly.
      upd_req = 1'b0;
      open_window();
      tick();
      check("open_no_req", upd_grant, 1'b0);
      set_pos(0, 523);
      tick();
      check("open_we_abort", upd_abort, 1'b0);
      upd_req = 1'b1;
      set_pos(1, 524);
      repeat (2) tick();
      check("no_grant_after_we", upd_grant, 1'b0);
      check("open_we_cnt", overrun_cnt, 8'd1);

      // upd_done coincident with window end.
      open_window();
      check("simul_grant", upd_grant, 1'b1);
      set_pos(0, 523); upd_done = 1'b1;
      tick();
      upd_done = 1'b0; set_pos(1, 524);
      check("simul_grant_fall", upd_grant, 1'b0);
      check("simul_no_abort", upd_abort, 1'b0);
      check("simul_cnt", overrun_cnt, 8'd1);
      tick();
      check("simul_no_abort2", upd_abort, 1'b0);

      // 300 further overruns; counter saturates at 255.
      exp_cnt = 1;
      for (int i = 0; i < 300; i++) begin
         open_window();
         set_pos(0, 523);
         tick();
         exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
         check($sformatf("sat_cnt%0d", i), overrun_cnt, exp_cnt);
         set_pos(1, 524);
         tick();
      end
      check("sat_final", overrun_cnt, 8'd255);

      // Reset mid-grant while a visible pixel is on screen.
      open_window();
      check("rst_pre_grant", upd_grant, 1'b1);
      set_pos(10, 20); layer_hit = 4'b0001;
      repeat (3) tick();
      check("rst_pre_rgb", rgb, 12'hA01);
      check("rst_pre_grant2", upd_grant, 1'b1);
      #2;
      clrn = 1'b0;
      #1;
      check("rst_drop_grant", upd_grant, 1'b0);
      check("rst_drop_rgb", rgb, 12'h000);
      check("rst_drop_cnt", overrun_cnt, 8'd0);
      layer_hit = 4'b0000;
      set_pos(0, 490);
      #1;
      clrn = 1'b1;
      rows_after = '{490, 500, 523, 524, 0, 100, 300};
      for (int i = 0; i < 7; i++) begin
         set_pos(0, rows_after[i]);
         tick();
         check($sformatf("post_rst_row%0d", rows_after[i]), upd_grant, 1'b0);
      end
      set_pos(0, 480);
      tick();
      check("post_rst_frame_tick", frame_tick, 1'b1);
      set_pos(1, 480);
      tick();
      check("post_rst_grant", upd_grant, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
